// File: rtl/mips_pipe_pkg.sv
// ---------------------------------------------------------------------------
// mips_pipe_pkg
// Shared constants for the pipelined MIPS datapath front end.
//   INSTR_W     : default instruction width
//   PC_W        : default PC+4 width
//   NOP_INSTR   : value presented to decode when no word is held
//   STALL_CNT_W : width of the optional decode-stall counter
//                 (IF_ID_STALL_COUNT_EN)
// ---------------------------------------------------------------------------
package mips_pipe_pkg;

   localparam int INSTR_W     = 32;
   localparam int PC_W        = 32;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
   localparam int STALL_CNT_W = 16;

   // Saturating increment for the stall counter: sticks at all-ones.
   function automatic logic [STALL_CNT_W-1:0] stall_sat_inc(
      input logic [STALL_CNT_W-1:0] i_val
   );
      return (i_val == '1) ? i_val : i_val + 1'b1;
   endfunction

endpackage

// File: rtl/if_id_skid_register_skid_slot.sv
// ---------------------------------------------------------------------------
// skid_slot
// One holding entry of the IF/ID register: a valid bit plus the
// instruction and PC+4 it qualifies.
//   Clk, Reset : clock, asynchronous active-high reset (clears everything)
//   i_clear    : drop the entry; valid and data return to 0/NOP
//   i_load     : capture i_instr / i_pc and mark valid (i_clear wins)
//   o_valid, o_instr, o_pc : current contents
// ---------------------------------------------------------------------------
module skid_slot
   import mips_pipe_pkg::*;
#(
   parameter int INSTR_W = mips_pipe_pkg::INSTR_W,
   parameter int PC_W    = mips_pipe_pkg::PC_W
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic               i_clear,
   input  logic               i_load,
   input  logic [INSTR_W-1:0] i_instr,
   input  logic [PC_W-1:0]    i_pc,
   output logic               o_valid,
   output logic [INSTR_W-1:0] o_instr,
   output logic [PC_W-1:0]    o_pc
);

   logic               r_valid;
   logic [INSTR_W-1:0] r_instr;
   logic [PC_W-1:0]    r_pc;

   // Data is cleared alongside valid so an empty slot always reads as NOP/0.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_valid <= 1'b0;
         r_instr <= INSTR_W'(NOP_INSTR);
         r_pc    <= '0;
      end else if (i_clear) begin
         r_valid <= 1'b0;
         r_instr <= INSTR_W'(NOP_INSTR);
         r_pc    <= '0;
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_instr <= i_instr;
         r_pc    <= i_pc;
      end
   end

   assign o_valid = r_valid;
   assign o_instr = r_instr;
   assign o_pc    = r_pc;

endmodule

// File: rtl/if_id_skid_register.sv
// ---------------------------------------------------------------------------
// if_id_skid_register
// IF/ID pipeline register with a two-entry skid buffer. Fetch writes via a
// valid/ready handshake; decode reads from the main entry. When decode
// stalls, one extra word is parked in the skid entry, so in_ready can be a
// pure flop output (NOT skid_valid) with no combinational path from
// out_ready back to fetch. flush kills both entries and any incoming word.
//
// Ports:
//   Clk, Reset        : clock, asynchronous active-high reset
//   in_valid/in_ready : fetch handshake
//   in_instruction    : fetched instruction
//   in_pc_plus4       : PC+4 of the fetched instruction
//   flush             : synchronous kill (taken branch / jump)
//   out_valid/out_ready : decode handshake
//   out_instruction   : held instruction, [15:0] feeds sign extension
//   out_pc_plus4      : held PC+4
//   stall_count       : (IF_ID_STALL_COUNT_EN only) saturating count of
//                       cycles with out_valid & !out_ready
//
// Configuration macro: IF_ID_STALL_COUNT_EN
// ---------------------------------------------------------------------------
module if_id_skid_register
   import mips_pipe_pkg::*;
#(
   parameter int INSTR_W = mips_pipe_pkg::INSTR_W,
   parameter int PC_W    = mips_pipe_pkg::PC_W
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [INSTR_W-1:0] in_instruction,
   input  logic [PC_W-1:0]    in_pc_plus4,
   input  logic               flush,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [INSTR_W-1:0] out_instruction,
`ifdef IF_ID_STALL_COUNT_EN
   output logic [PC_W-1:0]    out_pc_plus4,
   output logic [STALL_CNT_W-1:0] stall_count
`else
   output logic [PC_W-1:0]    out_pc_plus4
`endif
);

   logic               w_main_valid;
   logic [INSTR_W-1:0] w_main_instr;
   logic [PC_W-1:0]    w_main_pc;
   logic               w_skid_valid;
   logic [INSTR_W-1:0] w_skid_instr;
   logic [PC_W-1:0]    w_skid_pc;

   logic               w_accept;
   logic               w_consume;
   logic               w_main_load;
   logic               w_main_clear;
   logic               w_main_from_skid;
   logic               w_skid_load;
   logic               w_skid_clear;
   logic [INSTR_W-1:0] w_main_instr_d;
   logic [PC_W-1:0]    w_main_pc_d;

   assign in_ready  = ~w_skid_valid;
   assign w_accept  = in_valid & in_ready;
   assign w_consume = w_main_valid & out_ready;

   // Edge update priority: flush, skid drain, then accept.
   always_comb begin
      w_main_load      = 1'b0;
      w_main_clear     = 1'b0;
      w_main_from_skid = 1'b0;
      w_skid_load      = 1'b0;
      w_skid_clear     = 1'b0;
      if (flush) begin
         w_main_clear = 1'b1;
         w_skid_clear = 1'b1;
      end else if (w_skid_valid && w_consume) begin
         // in_ready is low here, so nothing new can arrive this cycle.
         w_main_load      = 1'b1;
         w_main_from_skid = 1'b1;
         w_skid_clear     = 1'b1;
      end else if (!w_main_valid || w_consume) begin
         if (w_accept) w_main_load  = 1'b1;
         else          w_main_clear = 1'b1;
      end else if (w_accept) begin
         // Main is stalled; park the new word so it is not dropped.
         w_skid_load = 1'b1;
      end
   end

   assign w_main_instr_d = w_main_from_skid ? w_skid_instr : in_instruction;
   assign w_main_pc_d    = w_main_from_skid ? w_skid_pc    : in_pc_plus4;

   skid_slot #(.INSTR_W(INSTR_W), .PC_W(PC_W)) u_main (
      .Clk     (Clk),
      .Reset   (Reset),
      .i_clear (w_main_clear),
      .i_load  (w_main_load),
      .i_instr (w_main_instr_d),
      .i_pc    (w_main_pc_d),
      .o_valid (w_main_valid),
      .o_instr (w_main_instr),
      .o_pc    (w_main_pc)
   );

   skid_slot #(.INSTR_W(INSTR_W), .PC_W(PC_W)) u_skid (
      .Clk     (Clk),
      .Reset   (Reset),
      .i_clear (w_skid_clear),
      .i_load  (w_skid_load),
      .i_instr (in_instruction),
      .i_pc    (in_pc_plus4),
      .o_valid (w_skid_valid),
      .o_instr (w_skid_instr),
      .o_pc    (w_skid_pc)
   );

   assign out_valid       = w_main_valid;
   assign out_instruction = w_main_instr;
   assign out_pc_plus4    = w_main_pc;

`ifdef IF_ID_STALL_COUNT_EN
   logic [STALL_CNT_W-1:0] r_stall_count;

   // Deliberately not touched by flush: it measures decode back-pressure.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_stall_count <= '0;
      end else if (w_main_valid && !out_ready) begin
         r_stall_count <= stall_sat_inc(r_stall_count);
      end
   end

   assign stall_count = r_stall_count;
`endif

endmodule

// File: tb/tb_if_id_skid_register.sv
module tb_if_id_skid_register;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instruction;
   logic [31:0] in_pc_plus4;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instruction;
   logic [31:0] out_pc_plus4;
`ifdef IF_ID_STALL_COUNT_EN
   logic [15:0] stall_count;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 Clk = ~Clk;

   if_id_skid_register dut (
      .Clk             (Clk),
      .Reset           (Reset),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .in_instruction  (in_instruction),
      .in_pc_plus4     (in_pc_plus4),
      .flush           (flush),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_instruction (out_instruction),
`ifdef IF_ID_STALL_COUNT_EN
      .out_pc_plus4    (out_pc_plus4),
      .stall_count     (stall_count)
`else
      .out_pc_plus4    (out_pc_plus4)
`endif
   );

   // Advance to just after the next rising edge; outputs settle, inputs may change.
   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic drive_idle();
      in_valid       = 1'b0;
      in_instruction = 32'h0;
      in_pc_plus4    = 32'h0;
      flush          = 1'b0;
   endtask

   task automatic do_reset();
      drive_idle();
      out_ready = 1'b1;
      Reset     = 1'b1;
      step();
      step();
      Reset = 1'b0;
      step();
   endtask

   // Fill main with a then skid with b while decode stalls.
   task automatic fill_both(input logic [31:0] a, input logic [31:0] b);
      out_ready = 1'b0;
      in_valid = 1'b1; in_instruction = a; in_pc_plus4 = 32'h00400004;
      step();
      in_instruction = b; in_pc_plus4 = 32'h00400008;
      step();
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_tests++;
      if (out_valid !== 1'b0 || out_instruction !== 32'h0 || out_pc_plus4 !== 32'h0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_state: got v=%b instr=%h pc=%h rdy=%b, want v=0 instr=0 pc=0 rdy=1",
                  out_valid, out_instruction, out_pc_plus4, in_ready);
      end
      // Mid-run reset with both entries full.
      fill_both(32'h2008000A, 32'h8C090004);
      n_tests++;
      if (in_ready !== 1'b0 || out_instruction !== 32'h2008000A) begin
         n_fail++;
         $display("FAIL reset_prefill: got rdy=%b instr=%h, want rdy=0 instr=2008000a", in_ready, out_instruction);
      end
      #2 Reset = 1'b1;
      #1;
      n_tests++;
      if (out_valid !== 1'b0 || out_instruction !== 32'h0 || out_pc_plus4 !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_async: got v=%b instr=%h pc=%h, want 0 0 0", out_valid, out_instruction, out_pc_plus4);
      end
      step();
      Reset = 1'b0;
      out_ready = 1'b1;
      step();
      n_tests++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release: got rdy=%b v=%b, want rdy=1 v=0", in_ready, out_valid);
      end
   endtask

   task automatic test_streaming();
      logic [31:0] words [3];
      logic [15:0] lows  [3];
      words[0] = 32'h2008000A; words[1] = 32'h8C090004; words[2] = 32'h1109FFFE;
      lows[0]  = 16'h000A;     lows[1]  = 16'h0004;     lows[2]  = 16'hFFFE;
      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_instruction = words[i];
         in_pc_plus4 = 32'h00400004 + 32'(4 * i);
         step();
         n_tests++;
         if (out_valid !== 1'b1 || out_instruction !== words[i] || out_instruction[15:0] !== lows[i] ||
             out_pc_plus4 !== 32'h00400004 + 32'(4 * i) || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL stream_%0d: got v=%b instr=%h pc=%h rdy=%b, want v=1 instr=%h low=%h",
                     i, out_valid, out_instruction, out_pc_plus4, in_ready, words[i], lows[i]);
         end
      end
      drive_idle();
      step();
      n_tests++;
      if (out_valid !== 1'b0 || out_instruction !== 32'h0) begin
         n_fail++;
         $display("FAIL stream_drain: got v=%b instr=%h, want v=0 instr=0", out_valid, out_instruction);
      end
   endtask

   task automatic test_stall();
      do_reset();
      fill_both(32'h2008000A, 32'h8C090004);
      n_tests++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_instruction !== 32'h2008000A || out_pc_plus4 !== 32'h00400004) begin
         n_fail++;
         $display("FAIL stall_skid_full: got rdy=%b v=%b instr=%h pc=%h, want rdy=0 v=1 instr=2008000a pc=00400004",
                  in_ready, out_valid, out_instruction, out_pc_plus4);
      end
      step();
      step();
      n_tests++;
      if (in_ready !== 1'b0 || out_instruction !== 32'h2008000A || out_pc_plus4 !== 32'h00400004) begin
         n_fail++;
         $display("FAIL stall_stable: got rdy=%b instr=%h pc=%h, want rdy=0 instr=2008000a pc=00400004",
                  in_ready, out_instruction, out_pc_plus4);
      end
      out_ready = 1'b1;
      step();
      n_tests++;
      if (out_valid !== 1'b1 || out_instruction !== 32'h8C090004 || out_pc_plus4 !== 32'h00400008 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL stall_release: got v=%b instr=%h pc=%h rdy=%b, want v=1 instr=8c090004 pc=00400008 rdy=1",
                  out_valid, out_instruction, out_pc_plus4, in_ready);
      end
      step();
      n_tests++;
      if (out_valid !== 1'b0 || out_instruction !== 32'h0) begin
         n_fail++;
         $display("FAIL stall_empty: got v=%b instr=%h, want v=0 instr=0", out_valid, out_instruction);
      end
   endtask

   task automatic test_flush();
      do_reset();
      fill_both(32'h2008000A, 32'h8C090004);
      in_valid = 1'b1; in_instruction = 32'hAC0B0008; in_pc_plus4 = 32'h0040000C;
      flush = 1'b1;
      step();
      n_tests++;
      if (out_valid !== 1'b0 || out_instruction !== 32'h0 || out_pc_plus4 !== 32'h0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL flush_full: got v=%b instr=%h pc=%h rdy=%b, want v=0 instr=0 pc=0 rdy=1",
                  out_valid, out_instruction, out_pc_plus4, in_ready);
      end
      drive_idle();
      out_ready = 1'b1;
      step();
      n_tests++;
      if (out_valid !== 1'b0 || out_instruction !== 32'h0) begin
         n_fail++;
         $display("FAIL flush_no_emit: got v=%b instr=%h, want v=0 instr=0", out_valid, out_instruction);
      end
      // Flush with main held and an acceptable word arriving the same cycle.
      in_valid = 1'b1; in_instruction = 32'h2008000A; in_pc_plus4 = 32'h00400004;
      out_ready = 1'b0;
      step();
      in_instruction = 32'hAC0B0008; in_pc_plus4 = 32'h00400008;
      flush = 1'b1;
      step();
      drive_idle();
      n_tests++;
      if (out_valid !== 1'b0 || out_instruction !== 32'h0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL flush_accept: got v=%b instr=%h rdy=%b, want v=0 instr=0 rdy=1", out_valid, out_instruction, in_ready);
      end
      out_ready = 1'b1;
      step();
      n_tests++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_accept_gone: got v=%b instr=%h, want v=0", out_valid, out_instruction);
      end
   endtask

   task automatic test_backpressure();
      localparam int N = 24;
      logic [31:0] exp_i [$];
      logic [31:0] exp_p [$];
      int sent = 0;
      int recv = 0;
      int cyc  = 0;
      logic        prev_stall = 1'b0;
      logic [31:0] prev_i = 32'h0;
      logic [31:0] prev_p = 32'h0;
      do_reset();
      while (recv < N && cyc < 1000) begin
         // Present next word (if any) and random back-pressure, then observe handshakes before the edge.
         in_valid = (sent < N) && ($urandom_range(0, 3) != 0);
         in_instruction = 32'h1000_0000 + 32'(sent);
         in_pc_plus4 = 32'h00400004 + 32'(4 * sent);
         out_ready = ($urandom_range(0, 2) != 0);
         #1;
         if (prev_stall) begin
            n_tests++;
            if (out_instruction !== prev_i || out_pc_plus4 !== prev_p || out_valid !== 1'b1) begin
               n_fail++;
               $display("FAIL bp_hold: got v=%b instr=%h pc=%h, want v=1 instr=%h pc=%h",
                        out_valid, out_instruction, out_pc_plus4, prev_i, prev_p);
            end
         end
         if (out_valid && out_ready) begin
            n_tests++;
            if (exp_i.size() == 0) begin
               n_fail++;
               $display("FAIL bp_extra: got instr=%h pc=%h, want no word", out_instruction, out_pc_plus4);
            end else begin
               if (out_instruction !== exp_i[0] || out_pc_plus4 !== exp_p[0]) begin
                  n_fail++;
                  $display("FAIL bp_order: got instr=%h pc=%h, want instr=%h pc=%h",
                           out_instruction, out_pc_plus4, exp_i[0], exp_p[0]);
               end
               void'(exp_i.pop_front());
               void'(exp_p.pop_front());
            end
            recv++;
         end
         if (in_valid && in_ready) begin
            exp_i.push_back(in_instruction);
            exp_p.push_back(in_pc_plus4);
            sent++;
         end
         prev_stall = out_valid && !out_ready;
         prev_i = out_instruction;
         prev_p = out_pc_plus4;
         @(posedge Clk);
         #1;
         cyc++;
      end
      drive_idle();
      n_tests++;
      if (recv !== N || exp_i.size() != 0) begin
         n_fail++;
         $display("FAIL bp_count: got recv=%0d pending=%0d, want recv=%0d pending=0", recv, exp_i.size(), N);
      end
   endtask

`ifdef IF_ID_STALL_COUNT_EN
   task automatic test_stall_count();
      do_reset();
      in_valid = 1'b1; in_instruction = 32'h2008000A; in_pc_plus4 = 32'h00400004;
      out_ready = 1'b0;
      step();
      in_valid = 1'b0;
      step(); step(); step();
      n_tests++;
      if (stall_count !== 16'd3) begin
         n_fail++;
         $display("FAIL stall_cnt_3: got %h, want 0003", stall_count);
      end
      flush = 1'b1;
      step();
      flush = 1'b0;
      n_tests++;
      if (stall_count !== 16'd4) begin
         n_fail++;
         $display("FAIL stall_cnt_flush: got %h, want 0004", stall_count);
      end
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      repeat (70000) @(posedge Clk);
      #1;
      n_tests++;
      if (stall_count !== 16'hFFFF) begin
         n_fail++;
         $display("FAIL stall_cnt_sat: got %h, want ffff", stall_count);
      end
      Reset = 1'b1;
      #1;
      n_tests++;
      if (stall_count !== 16'h0) begin
         n_fail++;
         $display("FAIL stall_cnt_reset: got %h, want 0000", stall_count);
      end
      step();
      Reset = 1'b0;
      out_ready = 1'b1;
      step();
   endtask
`endif

   initial begin
      Reset = 1'b0;
      out_ready = 1'b1;
      drive_idle();
      test_reset();
      test_streaming();
      test_stall();
      test_flush();
      test_backpressure();
`ifdef IF_ID_STALL_COUNT_EN
      test_stall_count();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
